// File: rtl/keypad_scan_if.sv
// Keypad-side bundle: the row return lines and column drive, plus the
// encoded key outputs that go to the calculator FSM.
interface keypad_scan_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [7:0] key_code;
  logic       pressed;
  logic       key_valid;

  // Keypad/bench side: drives the rows and observes everything else.
  modport master (
    output row_n,
    input  col_n,
    input  key_code,
    input  pressed,
    input  key_valid
  );

  // Encoder side: reads the rows and drives the columns and key outputs.
  modport slave (
    input  row_n,
    output col_n,
    output key_code,
    output pressed,
    output key_valid
  );
endinterface

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad scanner.
//
// The encoder walks one active-low column at a time. It freezes on the
// first key it sees, debounces that key's row, and reports it once. It then
// waits for a debounced release before scanning resumes.
//
// state     | meaning
// SCAN      | rotating columns, looking for any low row
// DEB_PRESS | key latched, counting consecutive low samples of its row
// HELD      | key accepted, counting consecutive high samples of its row
module keypad_scan_encoder #(
  parameter int SCAN_DIV = 250,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic           press_clk,
  input  logic           rst,
  keypad_scan_if.slave   kp
);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD} state_t;

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] deb_cnt, deb_nx;
  logic [3:0]       row_s1, row_s2;
  logic [3:0]       col_q, col_nx;
  logic [7:0]       code_q, code_nx;
  logic             pressed_q, pressed_nx;
  logic             valid_q, valid_nx;
  logic [1:0]       lat_row, lat_row_nx;
  logic [1:0]       lat_col, lat_col_nx;

  logic             strobe;
  logic             any_low;
  logic [1:0]       first_row;
  logic [1:0]       cur_col;
  logic             lat_low;
  logic [3:0]       col_rot;
  logic [CNT_W-1:0] deb_inc;

  assign kp.col_n     = col_q;
  assign kp.key_code  = code_q;
  assign kp.pressed   = pressed_q;
  assign kp.key_valid = valid_q;

  function automatic logic [7:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [7:0] code;
    case ({r, c})
      4'b00_00: code = 8'h01;
      4'b00_01: code = 8'h02;
      4'b00_10: code = 8'h03;
      4'b00_11: code = 8'hF0;
      4'b01_00: code = 8'h04;
      4'b01_01: code = 8'h05;
      4'b01_10: code = 8'h06;
      4'b01_11: code = 8'hF1;
      4'b10_00: code = 8'h07;
      4'b10_01: code = 8'h08;
      4'b10_10: code = 8'h09;
      4'b10_11: code = 8'hF2;
      4'b11_00: code = 8'hC0;
      4'b11_01: code = 8'h00;
      4'b11_10: code = 8'hE0;
      default:  code = 8'hF3;
    endcase
    return code;
  endfunction

  // Two-flop synchroniser on the row returns; idle rows read high.
  always_ff @(posedge press_clk or posedge rst) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= kp.row_n;
      row_s2 <= row_s1;
    end
  end

  // Free-running slot counter; its last count is the row sample strobe.
  always_ff @(posedge press_clk or posedge rst) begin
    if (rst) slot_cnt <= '0;
    else if (slot_cnt == SLOT_LAST) slot_cnt <= '0;
    else slot_cnt <= slot_cnt + ONE;
  end

  assign strobe  = (slot_cnt == SLOT_LAST);
  assign any_low = (row_s2 != 4'hF);
  assign lat_low = ~row_s2[lat_row];
  assign col_rot = {col_q[2:0], col_q[3]};
  assign deb_inc = deb_cnt + ONE;

  // Lowest low row wins when several rows in a column are pressed.
  always_comb begin
    first_row = 2'd3;
    if (!row_s2[0]) first_row = 2'd0;
    else if (!row_s2[1]) first_row = 2'd1;
    else if (!row_s2[2]) first_row = 2'd2;
  end

  // Column index of the single low bit in the column drive.
  always_comb begin
    case (col_q)
      4'b1110: cur_col = 2'd0;
      4'b1101: cur_col = 2'd1;
      4'b1011: cur_col = 2'd2;
      default: cur_col = 2'd3;
    endcase
  end

  // State register plus all registered outputs.
  always_ff @(posedge press_clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      deb_cnt   <= '0;
      col_q     <= 4'b1110;
      code_q    <= 8'hFF;
      pressed_q <= 1'b0;
      valid_q   <= 1'b0;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
    end else begin
      state     <= state_nx;
      deb_cnt   <= deb_nx;
      col_q     <= col_nx;
      code_q    <= code_nx;
      pressed_q <= pressed_nx;
      valid_q   <= valid_nx;
      lat_row   <= lat_row_nx;
      lat_col   <= lat_col_nx;
    end
  end

  // Next-state logic; every decision is taken only on a sample strobe.
  always_comb begin
    state_nx   = state;
    deb_nx     = deb_cnt;
    col_nx     = col_q;
    code_nx    = code_q;
    pressed_nx = pressed_q;
    valid_nx   = 1'b0;
    lat_row_nx = lat_row;
    lat_col_nx = lat_col;
    case (state)
      SCAN: begin
        if (strobe) begin
          if (any_low) begin
            lat_row_nx = first_row;
            lat_col_nx = cur_col;
            if (DEBOUNCE <= 1) begin
              // A single sample is enough: accept on the detecting strobe.
              state_nx   = HELD;
              deb_nx     = '0;
              code_nx    = key_map(first_row, cur_col);
              pressed_nx = 1'b1;
              valid_nx   = 1'b1;
            end else begin
              state_nx = DEB_PRESS;
              deb_nx   = ONE;
            end
          end else begin
            col_nx = col_rot;
          end
        end
      end
      DEB_PRESS: begin
        if (strobe) begin
          if (lat_low) begin
            if (deb_inc == DEB_LAST) begin
              state_nx   = HELD;
              deb_nx     = '0;
              code_nx    = key_map(lat_row, lat_col);
              pressed_nx = 1'b1;
              valid_nx   = 1'b1;
            end else begin
              deb_nx = deb_inc;
            end
          end else begin
            state_nx = SCAN;
            deb_nx   = '0;
            col_nx   = col_rot;
          end
        end
      end
      HELD: begin
        if (strobe) begin
          if (!lat_low) begin
            if (deb_inc == DEB_LAST) begin
              state_nx   = SCAN;
              deb_nx     = '0;
              code_nx    = 8'hFF;
              pressed_nx = 1'b0;
              col_nx     = col_rot;
            end else begin
              deb_nx = deb_inc;
            end
          end else begin
            deb_nx = '0;
          end
        end
      end
      default: begin
        state_nx = SCAN;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with SCAN_DIV=4, DEBOUNCE=3.
// A key matrix model closes rows onto the driven column combinationally.
module tb_keypad_scan_encoder;

  logic        press_clk;
  logic        rst;
  logic [15:0] keys;  // bit 4*row+col set while that key is held
  int          n_cmp;
  int          n_err;
  int          kv_count;
  int          kv0;

  keypad_scan_if kif ();

  keypad_scan_encoder #(.SCAN_DIV(4), .DEBOUNCE(3), .CNT_W(8)) dut (
    .press_clk (press_clk),
    .rst       (rst),
    .kp        (kif.slave)
  );

  assign kif.row_n[0] = ~|(keys[3:0]   & ~kif.col_n);
  assign kif.row_n[1] = ~|(keys[7:4]   & ~kif.col_n);
  assign kif.row_n[2] = ~|(keys[11:8]  & ~kif.col_n);
  assign kif.row_n[3] = ~|(keys[15:12] & ~kif.col_n);

  initial press_clk = 1'b0;
  always #5 press_clk = ~press_clk;

  // Count key_valid pulses as seen at each rising edge.
  always @(posedge press_clk) begin
    if (kif.key_valid === 1'b1) kv_count <= kv_count + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge press_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns one step after the edge where the column drive becomes c.
  task automatic wait_col(input logic [3:0] c, input string tag);
    int n;
    n = 0;
    while (kif.col_n === c && n < 40) begin tick(1); n++; end
    while (kif.col_n !== c && n < 80) begin tick(1); n++; end
    check(tag, {4'h0, kif.col_n}, {4'h0, c});
  endtask

  task automatic wait_release(input string tag);
    int n;
    n = 0;
    while (kif.pressed !== 1'b0 && n < 40) begin tick(1); n++; end
    check(tag, {7'h0, kif.pressed}, 8'h00);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    kv_count = 0;
    keys     = 16'h0;
    rst      = 1'b1;
    #12;
    check("rst_col", {4'h0, kif.col_n}, 8'h0E);
    check("rst_code", kif.key_code, 8'hFF);
    check("rst_pressed", {7'h0, kif.pressed}, 8'h00);
    check("rst_valid", {7'h0, kif.key_valid}, 8'h00);
    rst = 1'b0;

    // Idle scan: column rotates every 4 clocks.
    tick(3);
    check("idle_col_hold", {4'h0, kif.col_n}, 8'h0E);
    tick(1);
    check("idle_col1", {4'h0, kif.col_n}, 8'h0D);
    tick(4);
    check("idle_col2", {4'h0, kif.col_n}, 8'h0B);
    tick(4);
    check("idle_col3", {4'h0, kif.col_n}, 8'h07);
    tick(4);
    check("idle_col0", {4'h0, kif.col_n}, 8'h0E);
    check("idle_code", kif.key_code, 8'hFF);
    check("idle_kv", kv_count[7:0], 8'h00);

    // Key "6" (row1, col2), exact latency and release timing.
    wait_col(4'b1011, "k6_align");
    kv0 = kv_count;
    keys[6] = 1'b1;
    tick(11);
    check("k6_early_pressed", {7'h0, kif.pressed}, 8'h00);
    check("k6_early_valid", {7'h0, kif.key_valid}, 8'h00);
    tick(1);
    check("k6_valid", {7'h0, kif.key_valid}, 8'h01);
    check("k6_pressed", {7'h0, kif.pressed}, 8'h01);
    check("k6_code", kif.key_code, 8'h06);
    tick(1);
    check("k6_valid_pulse", {7'h0, kif.key_valid}, 8'h00);
    check("k6_code_hold", kif.key_code, 8'h06);
    tick(27);
    check("k6_code_late", kif.key_code, 8'h06);
    check("k6_col_frozen", {4'h0, kif.col_n}, 8'h0B);
    keys[6] = 1'b0;
    tick(11);
    check("k6_rel_pending", {7'h0, kif.pressed}, 8'h01);
    tick(1);
    check("k6_rel_pressed", {7'h0, kif.pressed}, 8'h00);
    check("k6_rel_code", kif.key_code, 8'hFF);
    check("k6_rel_col", {4'h0, kif.col_n}, 8'h07);
    check("k6_kv_once", 8'(kv_count - kv0), 8'h01);

    // Bounce on "0" (row3, col1): one low strobe then high.
    wait_col(4'b1101, "bounce_align");
    kv0 = kv_count;
    keys[13] = 1'b1;
    tick(4);
    check("bounce_col_frozen", {4'h0, kif.col_n}, 8'h0D);
    check("bounce_pressed", {7'h0, kif.pressed}, 8'h00);
    keys[13] = 1'b0;
    tick(4);
    check("bounce_col_next", {4'h0, kif.col_n}, 8'h0B);
    check("bounce_code", kif.key_code, 8'hFF);
    tick(4);
    check("bounce_scanning", {4'h0, kif.col_n}, 8'h07);
    check("bounce_kv", 8'(kv_count - kv0), 8'h00);

    // "=" (row3, col2) held, then "+" (row0, col3) added while held.
    wait_col(4'b1011, "eq_align");
    kv0 = kv_count;
    keys[14] = 1'b1;
    tick(12);
    check("eq_valid", {7'h0, kif.key_valid}, 8'h01);
    check("eq_code", kif.key_code, 8'hE0);
    tick(1);
    keys[3] = 1'b1;
    tick(20);
    check("eq_plus_ignored", kif.key_code, 8'hE0);
    check("eq_col_frozen", {4'h0, kif.col_n}, 8'h0B);
    keys[14] = 1'b0;
    tick(11);
    check("eq_rel_pressed", {7'h0, kif.pressed}, 8'h00);
    check("eq_rel_code", kif.key_code, 8'hFF);
    check("eq_rel_col", {4'h0, kif.col_n}, 8'h07);
    tick(11);
    check("plus_early", {7'h0, kif.pressed}, 8'h00);
    tick(1);
    check("plus_valid", {7'h0, kif.key_valid}, 8'h01);
    check("plus_code", kif.key_code, 8'hF0);
    check("eq_kv_once", 8'(kv_count - kv0), 8'h01);
    keys[3] = 1'b0;
    wait_release("plus_release");

    // Rows 0 and 2 low in column 0: lowest row ("1") wins.
    wait_col(4'b1110, "multi_align");
    keys[0] = 1'b1;
    keys[8] = 1'b1;
    tick(12);
    check("multi_valid", {7'h0, kif.key_valid}, 8'h01);
    check("multi_code", kif.key_code, 8'h01);
    keys[0] = 1'b0;
    keys[8] = 1'b0;
    wait_release("multi_release");

    // "C" (row3, col0) held across an asynchronous reset.
    wait_col(4'b1110, "clr_align");
    keys[12] = 1'b1;
    tick(12);
    check("clr_code", kif.key_code, 8'hC0);
    tick(5);
    kv0 = kv_count;
    rst = 1'b1;
    #1;
    check("clr_rst_col", {4'h0, kif.col_n}, 8'h0E);
    check("clr_rst_code", kif.key_code, 8'hFF);
    check("clr_rst_pressed", {7'h0, kif.pressed}, 8'h00);
    tick(2);
    rst = 1'b0;
    tick(11);
    check("clr_re_early", {7'h0, kif.pressed}, 8'h00);
    tick(1);
    check("clr_re_valid", {7'h0, kif.key_valid}, 8'h01);
    check("clr_re_code", kif.key_code, 8'hC0);
    tick(1);
    check("clr_re_pulse", {7'h0, kif.key_valid}, 8'h00);
    check("clr_kv_once", 8'(kv_count - kv0), 8'h01);
    keys[12] = 1'b0;
    wait_release("clr_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan_encoder.md
Name: keypad_scan_encoder

Overview:
Upstream stage of the calculator FSM. It scans a 4x4 matrix keypad, debounces the first key it detects, and encodes that key into the 8-bit key code the FSM consumes. It delivers the code together with a debounced pressed level and a one-cycle new-key pulse. It produces exactly one press event per physical keystroke.

Parameters:
SCAN_DIV, 250, press_clk cycles each column stays driven; rows are sampled on the last cycle of each slot
DEBOUNCE, 4, consecutive matching samples needed to accept a press, and also to accept a release
CNT_W, 8, width of the slot and debounce counters; must satisfy 2^CNT_W > max(SCAN_DIV, DEBOUNCE)

Ports:
press_clk  input   1  block clock
rst        input   1  asynchronous, active-high reset
row_n      input   4  keypad rows, active-low with external pull-ups, synchronised internally through 2 flops
col_n      output  4  column drive, one-hot active-low
key_code   output  8  encoded key; 8'hFF when no key is accepted
pressed    output  1  high while a debounced key is held
key_valid  output  1  one-cycle pulse when a press is accepted

Behaviour:
- Reset: rst is asynchronous and active-high; the clock is press_clk.
- Reset values: col_n=4'b1110, state=SCAN, key_code=8'hFF, pressed=0, key_valid=0, all counters 0, synchroniser flops = 4'hF.
- Key map (row r, col c):
  - r0: 1 2 3 +
  - r1: 4 5 6 -
  - r2: 7 8 9 *
  - r3: C 0 = /
- Codes:
  - digits 0-9 -> 8'h00-8'h09
  - + F0, - F1, * F2, / F3
  - = E0
  - C C0
- Slot counter counts 0..SCAN_DIV-1 and wraps. The sample strobe fires when the count is SCAN_DIV-1. Rows are taken from the synchronised row_n.
- State machine:
  - SCAN:
    - On each strobe with no row low, rotate col_n left (1110->1101->1011->0111->1110).
    - On a strobe with any row low, latch (row, col) and go to DEB_PRESS with deb_cnt=1. col_n stays frozen.
  - DEB_PRESS:
    - On each strobe, if the latched row is still low, deb_cnt++.
    - When deb_cnt reaches DEBOUNCE, go to HELD. In that same cycle load key_code from the map, set pressed=1, and pulse key_valid for 1 cycle.
    - If the latched row is high at a strobe, return to SCAN, reset deb_cnt to 0, and rotate to the next column.
  - HELD:
    - col_n stays frozen. deb_cnt counts consecutive strobes where the latched row is high.
    - Any strobe with that row low clears deb_cnt.
    - When deb_cnt reaches DEBOUNCE, go to SCAN, set key_code=8'hFF and pressed=0 in the same cycle, and rotate to the next column.
- Latency: the minimum from a stable press in the active column to key_valid is DEBOUNCE strobes plus the 2-cycle synchroniser.
- Multiple rows low in the same column: the lowest row index wins.
- Other keys pressed while in DEB_PRESS or HELD are ignored. Only the latched key is tracked, so no second event occurs until it is released.
- key_valid never pulses twice without an intervening release. It is always coincident with the rising edge of pressed.
- key_code is stable for the whole time pressed=1.
- Reset mid-debounce or mid-hold returns to the reset values immediately. No key_valid is produced.
- DEBOUNCE=1 is legal: acceptance happens on the first strobe that sees the key.

Test Plan:
- Sim params SCAN_DIV=4, DEBOUNCE=3, no key pressed. -> col_n cycles 1110,1101,1011,0111 every 4 clocks; key_code=FF; pressed=0; key_valid never pulses.
- Hold row1 low in column 2 (key "6") for 40 clocks, then release. -> one key_valid pulse; key_code=8'h06 and pressed=1 until 3 high strobes after release; then key_code=FF and pressed=0.
- Bounce: row3 low while column 1 is active ("0") for 1 strobe, then high for 1 strobe. -> returns to SCAN; no key_valid; key_code stays FF.
- Press "=" (r3,c2), then also press "+" (r0,c3) while "=" is held. -> a single event with key_code=8'hE0; "+" is ignored until "=" is released.
- Row0 and row2 both low in column 0. -> key_code=8'h01 (lowest row wins).
- Assert rst while in HELD with key_code=8'hC0. -> asynchronously col_n=1110, key_code=FF, pressed=0; after rst is released with the key still held, exactly one new key_valid with C0.
